// File: rtl/spi_master.sv
// spi_master: free-running SPI mode-0 master, 8-bit frames sent MSB first.
// A divided spi_clk drives a four-state frame sequencer that loads the
// transmit byte, shifts it out on falling spi_clk events, samples miso on
// rising events, and publishes the received byte at the end of each frame.
// There is no start strobe: a new frame begins every 10 spi_clk periods
// for as long as reset is low.
module spi_master #(
  parameter int DIV_HALF = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic       o_spi_clk,
  output logic       o_cs,
  output logic       o_mosi,
  input  logic       i_miso,
  input  logic [7:0] i_data_wr,
  output logic [7:0] o_data_rd,
  output logic [3:0] o_state,
  output logic [3:0] o_count
);

  // The state register is four bits wide so that encodings 4..15 stay
  // visible on the debug port and can be steered back to IDLE.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_TRANSFER = 4'd2,
    ST_DONE     = 4'd3
  } stateT;

  // The divider needs at least one bit, even when DIV_HALF is 1.
  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_spiClk;
  stateT            r_state;
  logic             r_cs;
  logic             r_mosi;
  logic [3:0]       r_count;
  logic [6:0]       r_txShift;
  logic [6:0]       r_rxShift;
  logic [7:0]       r_dataRd;

  logic             w_tick;
  logic             w_rise;
  logic             w_fall;
  stateT            w_stateNext;
  logic             w_csNext;
  logic             w_mosiNext;
  logic [3:0]       w_countNext;
  logic [6:0]       w_txNext;
  logic [6:0]       w_rxNext;
  logic [7:0]       w_dataRdNext;

  // A tick is the last system clock of a half period. The clk edge that
  // ends a low half is the "rise" event, and the edge that ends a high
  // half is the "fall" event.
  assign w_tick = (r_div == DIV_LAST);
  assign w_rise = w_tick & ~r_spiClk;
  assign w_fall = w_tick & r_spiClk;

  // Half-period counter; spi_clk toggles each time the counter wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div    <= '0;
      r_spiClk <= 1'b0;
    end else if (w_tick) begin
      r_div    <= '0;
      r_spiClk <= ~r_spiClk;
    end else begin
      r_div    <= r_div + 1'b1;
    end
  end

  // Frame sequencer: the state moves only on rise events, while the
  // transmit shifter also acts on fall events during TRANSFER.
  always_comb begin
    w_stateNext  = r_state;
    w_csNext     = r_cs;
    w_mosiNext   = r_mosi;
    w_countNext  = r_count;
    w_txNext     = r_txShift;
    w_rxNext     = r_rxShift;
    w_dataRdNext = r_dataRd;

    case (r_state)
      ST_IDLE: begin
        w_csNext = 1'b1;
        if (w_rise) begin
          // Latch the whole byte now. Bit 7 goes straight onto mosi, so
          // only bits 6..0 need to wait in the shifter.
          w_stateNext = ST_LOAD;
          w_csNext    = 1'b0;
          w_mosiNext  = i_data_wr[7];
          w_txNext    = i_data_wr[6:0];
          w_rxNext    = '0;
          w_countNext = 4'd0;
        end
      end

      ST_LOAD: begin
        if (w_rise) begin
          w_stateNext = ST_TRANSFER;
          w_rxNext    = {6'd0, i_miso};
          w_countNext = 4'd1;
        end
      end

      ST_TRANSFER: begin
        if (w_fall) begin
          w_mosiNext = r_txShift[6];
          w_txNext   = {r_txShift[5:0], 1'b0};
        end
        if (w_rise) begin
          if (r_count < 4'd7) begin
            w_rxNext    = {r_rxShift[5:0], i_miso};
            w_countNext = r_count + 4'd1;
          end else begin
            // The eighth sample completes the byte without passing
            // through the shifter.
            w_dataRdNext = {r_rxShift, i_miso};
            w_countNext  = 4'd8;
            w_csNext     = 1'b1;
            w_mosiNext   = 1'b0;
            w_stateNext  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (w_rise) begin
          w_stateNext = ST_IDLE;
          w_countNext = 4'd0;
        end
      end

      default: begin
        // Unreachable encodings: release the slave at once and return to
        // IDLE on the next rise.
        w_csNext   = 1'b1;
        w_mosiNext = 1'b0;
        if (w_rise) begin
          w_stateNext = ST_IDLE;
        end
      end
    endcase
  end

  // Register every sequencer output so that the pins never glitch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
      r_count   <= 4'd0;
      r_txShift <= '0;
      r_rxShift <= '0;
      r_dataRd  <= 8'd0;
    end else begin
      r_state   <= w_stateNext;
      r_cs      <= w_csNext;
      r_mosi    <= w_mosiNext;
      r_count   <= w_countNext;
      r_txShift <= w_txNext;
      r_rxShift <= w_rxNext;
      r_dataRd  <= w_dataRdNext;
    end
  end

  assign o_spi_clk = r_spiClk;
  assign o_cs      = r_cs;
  assign o_mosi    = r_mosi;
  assign o_data_rd = r_dataRd;
  assign o_state   = r_state;
  assign o_count   = r_count;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master. The first instance
// (DIV_HALF=1) has miso looped back to mosi. The second instance
// (DIV_HALF=4) has miso held high.
`timescale 1ns/1ps
module tb_spi_master;

  logic       clk;
  logic       reset;
  logic [7:0] dataWr;
  logic       miso2;

  logic       spiClk, cs, mosi, miso;
  logic [7:0] dataRd;
  logic [3:0] state, count;

  logic       spiClk2, cs2, mosi2;
  logic [7:0] dataRd2;
  logic [3:0] state2, count2;

  int checks   = 0;
  int failures = 0;

  // The loopback makes every received byte equal to the transmitted one.
  assign miso = mosi;

  spi_master #(.DIV_HALF(1)) dut (
    .i_clk(clk), .i_reset(reset), .o_spi_clk(spiClk), .o_cs(cs),
    .o_mosi(mosi), .i_miso(miso), .i_data_wr(dataWr), .o_data_rd(dataRd),
    .o_state(state), .o_count(count)
  );

  spi_master #(.DIV_HALF(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .o_spi_clk(spiClk2), .o_cs(cs2),
    .o_mosi(mosi2), .i_miso(miso2), .i_data_wr(dataWr), .o_data_rd(dataRd2),
    .o_state(state2), .o_count(count2)
  );

  // 100 ns system clock.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [7:0] wr);
    @(negedge clk);
    reset  = rst;
    dataWr = wr;
  endtask

  // Called at a negedge. Returns at the first negedge after a rise event of
  // the DIV_HALF=1 instance, together with the cs and mosi values the slave
  // saw just before that rise.
  task automatic waitRise(output logic preCs, output logic preMosi);
    logic lastClk, lastCs, lastMosi;
    logic seen;
    seen     = 1'b0;
    lastClk  = spiClk;
    lastCs   = cs;
    lastMosi = mosi;
    preCs    = 1'b1;
    preMosi  = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (spiClk && !lastClk) begin
        seen    = 1'b1;
        preCs   = lastCs;
        preMosi = lastMosi;
      end else begin
        lastClk  = spiClk;
        lastCs   = cs;
        lastMosi = mosi;
      end
    end
    if (!seen) checkOutput("riseTimeout", {7'd0, seen}, 8'd1);
  endtask

  // Runs one 10-rise frame that starts from IDLE.
  task automatic runFrame(input logic [7:0] expTx, input logic [7:0] expPrevRd,
                          input bit changeMid, input logic [7:0] newWr);
    logic       pc, pm;
    logic [7:0] txSeen;
    logic [3:0] expState, expCount;
    int         csLow;
    txSeen = 8'd0;
    csLow  = 0;
    for (int k = 1; k <= 10; k++) begin
      waitRise(pc, pm);
      if (!pc) begin
        csLow++;
        txSeen = {txSeen[6:0], pm};
      end
      if (k == 1)      begin expState = 4'd1; expCount = 4'd0;       end
      else if (k <= 8) begin expState = 4'd2; expCount = 4'(k - 1);  end
      else if (k == 9) begin expState = 4'd3; expCount = 4'd8;       end
      else             begin expState = 4'd0; expCount = 4'd0;       end
      checkOutput($sformatf("state_r%0d", k), {4'd0, state}, {4'd0, expState});
      checkOutput($sformatf("count_r%0d", k), {4'd0, count}, {4'd0, expCount});
      if (k == 1) begin
        checkOutput("csLoad", {7'd0, cs}, 8'd0);
        checkOutput("mosiFirst", {7'd0, mosi}, {7'd0, expTx[7]});
      end
      if (k == 4 && changeMid) dataWr = newWr;
      if (k == 8) checkOutput("rdHold", dataRd, expPrevRd);
      if (k == 9) begin
        checkOutput("rdDone", dataRd, expTx);
        checkOutput("csDone", {7'd0, cs}, 8'd1);
        checkOutput("mosiDone", {7'd0, mosi}, 8'd0);
      end
    end
    checkOutput("txBits", txSeen, expTx);
    checkOutput("csLowRises", 8'(csLow), 8'd8);
  endtask

  // Directed sequence: reset, two back-to-back frames, a reset that aborts
  // a frame mid-transfer, then the divided instance.
  initial begin
    logic       pc, pm;
    int         riseT[3];
    int         nRise;
    logic       lastSpi2;
    logic       doneSeen;
    logic [7:0] rd2;
    logic [3:0] cnt2;

    reset  = 1'b1;
    dataWr = 8'hAB;
    miso2  = 1'b1;
    repeat (4) @(negedge clk);

    checkOutput("rstSpiClk", {7'd0, spiClk}, 8'd0);
    checkOutput("rstCs", {7'd0, cs}, 8'd1);
    checkOutput("rstMosi", {7'd0, mosi}, 8'd0);
    checkOutput("rstState", {4'd0, state}, 8'd0);
    checkOutput("rstCount", {4'd0, count}, 8'd0);
    checkOutput("rstDataRd", dataRd, 8'd0);
    checkOutput("rstDataRd4", dataRd2, 8'd0);
    checkOutput("rstCs4", {7'd0, cs2}, 8'd1);

    reset = 1'b0;
    // The byte is swapped to 3C mid-frame; the current frame must still
    // carry AB and the following frame 3C.
    runFrame(8'hAB, 8'h00, 1'b1, 8'h3C);
    runFrame(8'h3C, 8'hAB, 1'b0, 8'h3C);

    // Abort the third frame during TRANSFER.
    for (int k = 0; k < 5; k++) waitRise(pc, pm);
    checkOutput("midTransfer", {4'd0, state}, 8'd2);
    applyStimulus(1'b1, 8'h3C);
    @(negedge clk);
    checkOutput("abortCs", {7'd0, cs}, 8'd1);
    checkOutput("abortSpiClk", {7'd0, spiClk}, 8'd0);
    checkOutput("abortState", {4'd0, state}, 8'd0);
    checkOutput("abortCount", {4'd0, count}, 8'd0);
    checkOutput("abortMosi", {7'd0, mosi}, 8'd0);
    checkOutput("abortDataRd", dataRd, 8'd0);
    reset = 1'b0;
    waitRise(pc, pm);
    checkOutput("reloadState", {4'd0, state}, 8'd1);
    checkOutput("reloadCs", {7'd0, cs}, 8'd0);

    // The DIV_HALF=4 instance should show an 8-clk spi_clk period and
    // receive FF from the miso line held high.
    nRise    = 0;
    doneSeen = 1'b0;
    rd2      = 8'd0;
    cnt2     = 4'd0;
    riseT[0] = 0; riseT[1] = 0; riseT[2] = 0;
    lastSpi2 = spiClk2;
    for (int c = 0; c < 300 && !doneSeen; c++) begin
      @(negedge clk);
      if (spiClk2 && !lastSpi2 && nRise < 3) begin
        riseT[nRise] = c;
        nRise++;
      end
      lastSpi2 = spiClk2;
      if (state2 == 4'd3) begin
        doneSeen = 1'b1;
        rd2      = dataRd2;
        cnt2     = count2;
      end
    end
    checkOutput("div4Done", {7'd0, doneSeen}, 8'd1);
    checkOutput("div4Period", 8'(riseT[2] - riseT[1]), 8'd8);
    checkOutput("div4Rd", rd2, 8'hFF);
    checkOutput("div4Count", {4'd0, cnt2}, 8'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
